// File: rtl/zion_riscv_add_sub_pkg.sv
// Shared definitions for the pipelined add/sub/compare execution unit:
// op-bit positions, the op vector type and a parameter legality check.
package zion_riscv_add_sub_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_W   = 2;
  localparam int OP_UNS = 3;

  typedef logic [3:0] add_sub_op_t;

  // XLEN must be 32 or 64, STAGES 1, 2 or 4, and the chunks must divide evenly
  function automatic bit params_legal(input int xlen, input int stages);
    return ((xlen == 32) || (xlen == 64)) &&
           ((stages == 1) || (stages == 2) || (stages == 4)) &&
           ((xlen % stages) == 0);
  endfunction

endpackage

// File: rtl/zion_riscv_add_sub_pipe_exec_chunk.sv
// One registered CW-bit slice of the split carry chain. It owns the slot
// valid bit, the chunk sum, the carry passed to the next slice and an opaque
// payload (skewed operands, earlier result chunks, tag, op flags).
module zion_riscv_add_sub_chunk #(
  parameter int CW = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          up_valid,
  input  logic          down_adv,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  input  logic [PW-1:0] pay_in,
  output logic          advance,
  output logic          valid,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic [PW-1:0] pay
);

  logic          valid_q, valid_d;
  logic [CW-1:0] sum_q, sum_d;
  logic          cout_q, cout_d;
  logic [PW-1:0] pay_q, pay_d;
  logic [CW:0]   add_full;

  assign advance = !valid_q || down_adv;

  // Load a new slice result when the slot can move on; flush empties the slot
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    valid_d  = valid_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    pay_d    = pay_q;
    if (advance) begin
      valid_d = up_valid;
      sum_d   = add_full[CW-1:0];
      cout_d  = add_full[CW];
      pay_d   = pay_in;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      pay_q   <= pay_d;
    end
  end

  assign valid = valid_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign pay   = pay_q;

endmodule

// File: rtl/zion_riscv_add_sub_pipe_exec.sv
// Pipelined add/sub/compare unit for the integer EX stage. The carry chain is
// cut into STAGES registered chunks; stage k adds operand chunk k plus the
// carry registered by stage k-1. Less-than is derived at the last stage.
// Optional macro ZION_RISCV_ADDSUB_OVF_EN adds the out_ovf signed-overflow port.
module zion_riscv_add_sub_pipe_exec
  import zion_riscv_add_sub_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  add_sub_op_t      in_op,
  input  logic [XLEN-1:0]  in_s1,
  input  logic [XLEN-1:0]  in_s2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rslt,
  output logic             out_lt,
  output logic [TAG_W-1:0] out_tag
`ifdef ZION_RISCV_ADDSUB_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CW = XLEN / STAGES;
  localparam int PW = 3 * XLEN + TAG_W + 2;

  if (!params_legal(XLEN, STAGES)) begin : g_param_check
    $error("zion_riscv_add_sub_pipe_exec: illegal XLEN/STAGES combination");
  end

  // Index k is the input side of stage k; index STAGES is the final slot.
  logic [STAGES:0]  vld;
  logic [STAGES:0]  adv;
  logic [STAGES:0]  cy;
  logic [STAGES:0]  uns_a;
  logic [STAGES:0]  w_a;
  logic [XLEN-1:0]  s1_a  [STAGES+1];
  logic [XLEN-1:0]  s2_a  [STAGES+1];
  logic [XLEN-1:0]  rs_a  [STAGES+1];
  logic [TAG_W-1:0] tag_a [STAGES+1];

  logic [XLEN-1:0]  s1_in, s2_in;

  // Operand conditioning: invert s2 for sub, zero both when no op is selected
  always_comb begin
    s1_in = '0;
    s2_in = '0;
    if (in_op[OP_SUB]) begin
      s1_in = in_s1;
      s2_in = ~in_s2;
    end else if (in_op[OP_ADD]) begin
      s1_in = in_s1;
      s2_in = in_s2;
    end
  end

  assign vld[0]      = in_valid;
  assign cy[0]       = in_op[OP_SUB];
  assign uns_a[0]    = in_op[OP_UNS];
  assign w_a[0]      = in_op[OP_W];
  assign s1_a[0]     = s1_in;
  assign s2_a[0]     = s2_in;
  assign rs_a[0]     = '0;
  assign tag_a[0]    = in_tag;
  assign adv[STAGES] = out_ready;
  assign in_ready    = adv[0] || flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [PW-1:0]   pay_out;
    logic [CW-1:0]   sum_out;
    logic [XLEN-1:0] rs_raw;
    logic [XLEN-1:0] rs_next;

    zion_riscv_add_sub_chunk #(
      .CW(CW),
      .PW(PW)
    ) u_chunk (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .up_valid(vld[k]),
      .down_adv(adv[k+1]),
      .a       (s1_a[k][k*CW +: CW]),
      .b       (s2_a[k][k*CW +: CW]),
      .cin     (cy[k]),
      .pay_in  ({s1_a[k], s2_a[k], rs_a[k], tag_a[k], uns_a[k], w_a[k]}),
      .advance (adv[k]),
      .valid   (vld[k+1]),
      .sum     (sum_out),
      .cout    (cy[k+1]),
      .pay     (pay_out)
    );

    assign {s1_a[k+1], s2_a[k+1], rs_raw, tag_a[k+1], uns_a[k+1], w_a[k+1]} = pay_out;

    // Merge this stage's chunk into the result bits carried from earlier stages
    always_comb begin
      rs_next = rs_raw;
      rs_next[k*CW +: CW] = sum_out;
    end

    assign rs_a[k+1] = rs_next;
  end

  logic [XLEN-1:0] rslt_full, rslt_w;
  logic            w_mode, s1_msb, s2_msb, r_msb, ovf_full;
  logic            unused_ops;

  assign rslt_full  = rs_a[STAGES];
  assign s1_msb     = s1_a[STAGES][XLEN-1];
  assign s2_msb     = s2_a[STAGES][XLEN-1];
  assign r_msb      = rslt_full[XLEN-1];
  assign ovf_full   = (s1_msb == s2_msb) && (r_msb != s1_msb);
  assign unused_ops = ^{s1_a[STAGES], s2_a[STAGES]};

  if (XLEN > 32) begin : g_wmode
    assign w_mode = w_a[STAGES];
    assign rslt_w = {{(XLEN-32){rslt_full[31]}}, rslt_full[31:0]};
  end else begin : g_no_wmode
    logic unused_w;
    assign unused_w = w_a[STAGES];
    assign w_mode   = 1'b0;
    assign rslt_w   = rslt_full;
  end

  assign out_valid = vld[STAGES];
  assign out_tag   = tag_a[STAGES];
  assign out_rslt  = w_mode ? rslt_w : rslt_full;
  assign out_lt    = uns_a[STAGES] ? !cy[STAGES] : (r_msb ^ ovf_full);

`ifdef ZION_RISCV_ADDSUB_OVF_EN
  logic ovf_w;
  assign ovf_w   = (s1_a[STAGES][31] == s2_a[STAGES][31]) && (rslt_full[31] != s1_a[STAGES][31]);
  assign out_ovf = w_mode ? ovf_w : ovf_full;
`endif

  a_op_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> $onehot0({in_op[OP_ADD], in_op[OP_SUB]}));

endmodule

// File: tb/tb_zion_riscv_add_sub_pipe_exec.sv
// Randomised and directed bench for zion_riscv_add_sub_pipe_exec (XLEN=64,
// STAGES=4) with a queue-based reference model. Honours ZION_RISCV_ADDSUB_OVF_EN.
module tb_zion_riscv_add_sub_pipe_exec;

  localparam int XLEN   = 64;
  localparam int STAGES = 4;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_lt;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_s1, in_s2, out_rslt;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef ZION_RISCV_ADDSUB_OVF_EN
  logic             out_ovf;
`endif

  zion_riscv_add_sub_pipe_exec #(
    .XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_s1(in_s1), .in_s2(in_s2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_rslt(out_rslt),
    .out_lt(out_lt), .out_tag(out_tag)
`ifdef ZION_RISCV_ADDSUB_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Expected response of one accepted request
  typedef struct {
    logic [XLEN-1:0]  rslt;
    logic             lt;
    logic             chk_lt;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   n_out = 0;
  bit   check_lat = 1'b0;
  logic last_in_ready, last_accept;
  int   sent, j, out_before;
  bit   saw_block;

  // Cycle counter used for latency measurement
  always @(posedge clk) cycle <= cycle + 1;

  // Watchdog so the run can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference: plain arithmetic on the architectural meaning of each op
  function automatic exp_t model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tg);
    exp_t e;
    logic [XLEN-1:0]   r;
    logic signed [XLEN:0] wide;
    logic signed [32:0]   w32;
    e = '{default: 0};
    e.tag = tg;
    e.cyc = cycle;
    r = '0; wide = '0; w32 = '0;
    if (op[1]) begin
      r    = a - b;
      wide = $signed({a[XLEN-1], a}) - $signed({b[XLEN-1], b});
      w32  = $signed({a[31], a[31:0]}) - $signed({b[31], b[31:0]});
      e.chk_lt = 1'b1;
      e.lt = op[3] ? (a < b) : ($signed(a) < $signed(b));
    end else if (op[0]) begin
      r    = a + b;
      wide = $signed({a[XLEN-1], a}) + $signed({b[XLEN-1], b});
      w32  = $signed({a[31], a[31:0]}) + $signed({b[31], b[31:0]});
    end
    if (op[2]) begin
      e.rslt = {{32{r[31]}}, r[31:0]};
      e.ovf  = (w32[32] != w32[31]);
    end else begin
      e.rslt = r;
      e.ovf  = (wide[XLEN] != wide[XLEN-1]);
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic iv, input logic [3:0] op, input logic [XLEN-1:0] s1,
                               input logic [XLEN-1:0] s2, input logic [TAG_W-1:0] tg,
                               input logic ordy, input logic fl);
    exp_t e;
    @(negedge clk);
    in_valid = iv; in_op = op; in_s1 = s1; in_s2 = s2; in_tag = tg;
    out_ready = ordy; flush = fl;
    #1;
    last_in_ready = in_ready;
    last_accept = 1'b0;
    if (out_valid && out_ready) begin
      n_out++;
      if (expq.size() == 0) begin
        checkOutput("extra_out", XLEN'(out_valid), '0);
      end else begin
        e = expq.pop_front();
        checkOutput("rslt", out_rslt, e.rslt);
        checkOutput("tag", XLEN'(out_tag), XLEN'(e.tag));
        if (e.chk_lt) checkOutput("lt", XLEN'(out_lt), XLEN'(e.lt));
`ifdef ZION_RISCV_ADDSUB_OVF_EN
        checkOutput("ovf", XLEN'(out_ovf), XLEN'(e.ovf));
`endif
        if (check_lat) checkOutput("latency", XLEN'(cycle - e.cyc), XLEN'(STAGES));
      end
    end
    if (fl) begin
      expq.delete();
    end else if (iv && in_ready) begin
      expq.push_back(model(op, s1, s2, tg));
      last_accept = 1'b1;
    end
  endtask

  task automatic drainAll(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 60) begin
      applyStimulus(1'b0, 4'b0000, '0, '0, '0, 1'b1, 1'b0);
      n++;
    end
    checkOutput({name, "_drained"}, XLEN'(expq.size()), '0);
  endtask

  function automatic logic [XLEN-1:0] rndOperand();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = {XLEN{1'b1}};
      2:       v = {1'b1, {(XLEN-1){1'b0}}};
      3:       v = {1'b0, {(XLEN-1){1'b1}}};
      4:       v = XLEN'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic [3:0] op;
    int r;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_s1 = '0; in_s2 = '0; in_tag = '0; out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", XLEN'(out_valid), '0);
    checkOutput("rst_out_rslt", out_rslt, '0);
    checkOutput("rst_out_tag", XLEN'(out_tag), '0);
    checkOutput("rst_out_lt", XLEN'(out_lt), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_in_ready", XLEN'(in_ready), 64'd1);

    // Directed vectors, back to back, no backpressure
    check_lat = 1'b1;
    applyStimulus(1, 4'b0001, 64'h7FFF_FFFF, 64'd1, 5'd3, 1, 0);
    applyStimulus(1, 4'b0101, 64'h7FFF_FFFF, 64'd1, 5'd4, 1, 0);
    applyStimulus(1, 4'b0110, 64'd0, 64'd1, 5'd5, 1, 0);
    applyStimulus(1, 4'b0010, 64'd0, 64'd1, 5'd6, 1, 0);
    applyStimulus(1, 4'b0110, 64'h1_0000_0000, 64'd1, 5'd7, 1, 0);
    applyStimulus(1, 4'b0010, 64'h8000_0000_0000_0000, 64'd1, 5'd8, 1, 0);
    applyStimulus(1, 4'b1010, 64'h8000_0000_0000_0000, 64'd1, 5'd9, 1, 0);
    applyStimulus(1, 4'b0010, 64'd5, 64'd5, 5'd10, 1, 0);
    applyStimulus(1, 4'b1010, 64'd5, 64'd5, 5'd11, 1, 0);
    applyStimulus(1, 4'b0000, 64'h1234_5678_9ABC_DEF0, 64'h1111, 5'd12, 1, 0);
    applyStimulus(1, 4'b0001, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd13, 1, 0);
    applyStimulus(1, 4'b0001, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 5'd14, 1, 0);
    applyStimulus(1, 4'b0010, 64'h0001_0000_0000_0000, 64'd1, 5'd15, 1, 0);
    drainAll("directed");

    // Backpressure: eight adds i+i, consumer stalls cycles 3..6
    check_lat = 1'b0;
    sent = 0; j = 0; out_before = n_out; saw_block = 1'b0;
    while ((sent < 8 || expq.size() != 0) && j < 60) begin
      applyStimulus(sent < 8, 4'b0001, XLEN'(sent), XLEN'(sent), TAG_W'(sent),
                    !(j >= 3 && j <= 6), 1'b0);
      if (sent < 8 && !last_in_ready) saw_block = 1'b1;
      if (last_accept) sent++;
      j++;
    end
    checkOutput("bp_count", XLEN'(n_out - out_before), 64'd8);
    checkOutput("bp_in_ready_drop", XLEN'(saw_block), 64'd1);
    checkOutput("bp_drained", XLEN'(expq.size()), '0);

    // Flush with a full pipeline and a request offered in the flush cycle
    for (int i = 0; i < STAGES; i++) applyStimulus(1, 4'b0001, XLEN'(100 + i), 64'd1, TAG_W'(i), 0, 0);
    applyStimulus(1, 4'b0001, 64'd999, 64'd1, 5'd9, 0, 1);
    checkOutput("flush_in_ready", XLEN'(last_in_ready), 64'd1);
    applyStimulus(0, 4'b0000, '0, '0, '0, 1, 0);
    checkOutput("flush_out_valid", XLEN'(out_valid), '0);
    check_lat = 1'b1;
    applyStimulus(1, 4'b0010, 64'd50, 64'd8, 5'd7, 1, 0);
    drainAll("flush_follow");

    // Asynchronous reset mid-stream
    check_lat = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0001, XLEN'(i), 64'd3, TAG_W'(i + 1), 0, 0);
    repeat (STAGES) applyStimulus(0, 4'b0000, '0, '0, '0, 0, 0);
    checkOutput("pre_reset_valid", XLEN'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", XLEN'(out_valid), '0);
    checkOutput("async_out_rslt", out_rslt, '0);
    checkOutput("async_out_tag", XLEN'(out_tag), '0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_lat = 1'b1;
    applyStimulus(1, 4'b0110, 64'h1_0000_0000, 64'd1, 5'd5, 1, 0);
    drainAll("post_reset");

    // Random traffic with random backpressure and occasional flush
    check_lat = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      op = 4'b0000;
      if (r < 4) op[0] = 1'b1;
      else if (r < 9) op[1] = 1'b1;
      op[2] = 1'($urandom_range(0, 1));
      op[3] = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 3) != 0), op, rndOperand(), rndOperand(),
                    TAG_W'($urandom), 1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 49) == 0));
    end
    drainAll("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zion_riscv_add_sub_pipe_exec.md
Name: zion_riscv_add_sub_pipe_exec

Overview:
Pipelined, parametrised add/sub/compare execution unit for the integer EX stage.
- Supports RV32I/RV64I ADD[I], SUB, ADD[I]W, SUBW, SLT[I][U] and branch-compare less-than.
- The carry chain is split into STAGES registered chunks with a valid/ready handshake on each side. A tag is carried along for writeback routing.
- Sits between the decode/issue buffer and the writeback arbiter.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
STAGES, 2, pipeline depth and number of carry-chain chunks; legal values 1, 2, 4. XLEN/STAGES must be an integer.
TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of all in-flight operations.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request this cycle.
in_op  in  4  [0] add, [1] sub, [2] W (RV64 only; ignored when XLEN=32), [3] unsigned compare.
in_s1  in  XLEN  operand 1.
in_s2  in  XLEN  operand 2.
in_tag  in  TAG_W  pass-through tag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_rslt  out  XLEN  sum or difference; W-mode result is sign-extended from bit 31.
out_lt  out  1  less-than flag of s1 vs s2; meaningful only when sub=1.
out_tag  out  TAG_W  tag of the returned request.

Behaviour:
- Reset (rst_n=0, asynchronous): every stage valid=0; out_valid=0, out_rslt=0, out_lt=0, out_tag=0, in_ready=1 after the first clock. All pipeline state is dropped.
- Chunk arithmetic:
  - Chunk width CW = XLEN/STAGES. Stage k adds bits [k*CW +: CW] of s1 and s2' plus the registered carry from stage k-1.
  - s2' = ~s2 when sub, s2 when add. The carry-in to stage 0 = sub.
  - Upper operand chunks travel skewed alongside; lower result chunks are held until the final stage.
- Op decode: when neither add nor sub is set, s1 and s2 are treated as 0 (result 0). When both are set, the result is undefined, and the assertion below fires.
- Latency: exactly STAGES cycles from in accept to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
  - Stage k advances when its slot is empty or stage k+1 advances. The last stage advances when it is empty or out_ready=1.
  - in_ready = stage-0 slot can advance (combinational through the pipeline). Bubbles collapse.
  - Held out_* stay stable while out_valid & !out_ready.
- Less-than, computed at the final stage on the full XLEN (the W bit does not affect out_lt):
  - Unsigned (op[3]=1): lt = ~carry_out.
  - Signed: lt = rslt[XLEN-1] ^ ovf, where ovf = (s1[msb] == s2'[msb]) & (rslt[msb] != s1[msb]).
- W mode (XLEN=64): out_rslt = {{32{sum[31]}}, sum[31:0]}.
- Flush: all stage valids clear at the next edge. No request accepted in the flush cycle survives. out_valid=0 the cycle after. in_ready=1 during flush.
- Simultaneous in transfer and out transfer with a full pipeline is legal and sustains throughput.
- Assertion (simulation only): $onehot0({add, sub}) checked on every accepted request.

Optional Feature:
ZION_RISCV_ADDSUB_OVF_EN
- Defined: adds output port out_ovf (1 bit).
  - Signed overflow of the XLEN operation, or of the 32-bit operation in W mode.
  - Registered and aligned with out_valid. Reset value 0.
- Undefined: no port and no overflow register. Signed out_lt still computes ovf internally.

Decomposition:
- Shared package zion_riscv_add_sub_pkg:
  - op-bit index constants OP_ADD=0, OP_SUB=1, OP_W=2, OP_UNS=3.
  - typedef add_sub_op_t as logic [3:0].
  - a parameter-legality check function (XLEN in {32,64}, STAGES in {1,2,4}).
- Natural sub-module: zion_riscv_add_sub_chunk. One registered CW-bit adder slice with carry in/out and the valid/advance logic, instantiated STAGES times by a generate loop.

Test Plan:
- XLEN=32, STAGES=2, add: s1=0x7FFFFFFF, s2=1, tag=3 -> 2 cycles later out_rslt=0x80000000, out_tag=3, out_ovf=1 if enabled.
- XLEN=64, sub+W: s1=0, s2=1 -> out_rslt=0xFFFFFFFFFFFFFFFF. Same without W -> also all ones. Then s1=0x100000000, s2=1 with W -> 0xFFFFFFFFFFFFFFFF.
- Compare, XLEN=32: sub, s1=0x80000000, s2=1 -> signed out_lt=1, unsigned out_lt=0. s1=5, s2=5 -> out_lt=0 both ways.
- Backpressure: stream 8 back-to-back adds i+i with out_ready low for cycles 3-6 -> results 0,2,..,14 in order, none lost or duplicated, in_ready drops once STAGES slots fill.
- Flush with the pipeline full (STAGES=4) and in_valid=1 -> no out_valid the following cycle. The next request returns exactly 4 cycles after acceptance.
- Reset asserted mid-stream -> out_valid=0 immediately (asynchronous). After release, first accepted op returns correctly after STAGES cycles.
